// File: rtl/serial_adder_pkg.sv
// Shared state encoding and sizing helpers for the digit-serial adder.
// Imported by the top and the testbench-facing interface users.
package serial_adder_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter must be able to hold NDIG itself, hence n+1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus of the serial adder.
// master drives operands and start; slave returns status and result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder; each full adder is two half adders
// with their carries ORed. {co, s} forms the (DIGIT+1)-bit digit result.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    logic c_in, s1, c1, c2, c_out;

    // Carry chained through per-bit scopes rather than one shared vector.
    if (i == 0) begin : g_first
      assign c_in = ci;
    end else begin : g_next
      assign c_in = g_fa[i-1].c_out;
    end

    half_adder u_ha0 (.a(x[i]), .b(y[i]), .s(s1),   .c(c1));
    half_adder u_ha1 (.a(s1),   .b(c_in), .s(s[i]), .c(c2));
    assign c_out = c1 | c2;
  end

  assign co = g_fa[DIGIT-1].c_out;
endmodule

// File: rtl/half_adder.sv
// Legacy one-bit half adder cell, reused as the building block of digit_adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit a + b + cin, DIGIT bits per clock, LSB digit
// first. Result, carry-out and signed overflow are held until the next op.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cnt_width(NDIG);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder: WIDTH must be >=2 and a multiple of DIGIT");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh, work;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             a_msb, b_msb;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic [DIGIT-1:0]       dsum;
  logic                   dco;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0]       work_nx;
  logic                   load, last;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x  (a_sh[DIGIT-1:0]),
    .y  (b_sh[DIGIT-1:0]),
    .ci (carry),
    .s  (dsum),
    .co (dco)
  );

  // New digit enters at the MSB end; after NDIG shifts the sum is aligned.
  assign cat     = {dsum, work};
  assign work_nx = cat[WIDTH+DIGIT-1:DIGIT];
  assign last    = (cnt == CW'(NDIG - 1));
  assign load    = bus.start && (state == S_IDLE || state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      work   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (load) begin
      state <= S_RUN;
      a_sh  <= bus.a;
      b_sh  <= bus.b;
      carry <= bus.cin;
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
      work  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          carry <= dco;
          work  <= work_nx;
          cnt   <= cnt + CW'(1);
          if (last) begin
            state  <= S_DONE;
            sum_q  <= work_nx;
            cout_q <= dco;
            ovf_q  <= (a_msb == b_msb) && (work_nx[WIDTH-1] != a_msb);
          end
        end
        S_DONE:  state <= S_IDLE;
        S_IDLE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == S_RUN);
  assign bus.done     = (state == S_DONE);
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule
